mio_responder: RTL and testbench
================================

MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, BUSY-state wait cycles per access (0..15).
REQ-002 Parameter RAM_AW, default 10, word-address width of internal RAM (2^RAM_AW x 32 words).
REQ-003 Parameter IO_BASE, default 32'hF000_0000, base of the I/O window.
REQ-004 clk  input  1  rising-edge clock, the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_req  input  1  CPU access request, level, four-phase handshake.
REQ-007 mem_w  input  1  1 = write, 0 = read; sampled with mem_req.
REQ-008 M_addr  input  32  CPU byte address.
REQ-009 data_out  input  32  CPU write data.
REQ-010 sw_in  input  16  switch inputs, readable at IO_BASE+4.
REQ-011 data2CPU  output  32  read data to CPU.
REQ-012 MIO_ready  output  1  access complete / response valid.
REQ-013 led_out  output  16  LED register, writable at IO_BASE.
REQ-014 bus_err  output  1  misaligned or unmapped access flag for the current response.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE.
- IDLE: mem_req=1 -> latch M_addr, data_out, mem_w; go BUSY (WAIT_CYCLES>0) or DONE (WAIT_CYCLES=0).
- BUSY: count down WAIT_CYCLES cycles -> DONE.
- DONE: stay while mem_req=1; mem_req=0 -> IDLE.
REQ-016 Request accepted at edge N SHALL give MIO_ready=1 from edge N+1+WAIT_CYCLES.
REQ-017 MIO_ready SHALL be 1 only in DONE, else 0.
REQ-018 Changes to mem_req, mem_w, M_addr, data_out after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-019 Decode uses the latched address. RAM hit: addr[31:RAM_AW+2]==0. IO_BASE: LED register. IO_BASE+4: switches. Anything else: unmapped.
REQ-020 Misaligned access (addr[1:0]!=0) SHALL be treated as an error regardless of region.
REQ-021 On the DONE-entry edge, a write SHALL update RAM word addr[RAM_AW+1:2] or led_out (data_out[15:0]); the switch address and error accesses SHALL write nothing.
REQ-022 On the DONE-entry edge, a read SHALL load data2CPU with:
- RAM word, or
- {16'b0, led_out}, or
- {16'b0, sw_in} sampled on that edge, or
- 32'h0 on error.
REQ-023 On a write, data2CPU SHALL hold its previous value.
REQ-024 bus_err SHALL be loaded on the DONE-entry edge (1 = error access) and held until the next DONE entry.
REQ-025 mem_req already 1 on re-entry to IDLE is not possible; a request is accepted only after mem_req has been seen 0 in DONE.
REQ-026 The wait counter SHALL be 4 bits, reloaded on acceptance, and never wrap.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, MIO_ready=0, data2CPU=0, led_out=0, bus_err=0, and clear the counter, including mid-access.
REQ-028 reset SHALL NOT clear RAM contents.
REQ-029 A write aborted by reset before DONE entry SHALL not modify RAM or led_out.

Verification
REQ-030 WAIT_CYCLES=2: write 32'hDEADBEEF to 0x10, then read 0x10 -> MIO_ready rises 3 cycles after acceptance; data2CPU=32'hDEADBEEF; bus_err=0.
REQ-031 Write 32'h0000A5A5 to IO_BASE, then read IO_BASE -> led_out=16'hA5A5; data2CPU=32'h0000A5A5. With sw_in=16'h1234, read IO_BASE+4 -> data2CPU=32'h00001234.
REQ-032 Read 0x12 (misaligned) and read 0x8000_0000 (unmapped) -> data2CPU=0 and bus_err=1 for each; a RAM write to 0x12 leaves word 0x10 unchanged.
REQ-033 Hold mem_req=1 for 5 cycles after MIO_ready -> MIO_ready stays 1 and no second access occurs; drop mem_req -> IDLE next edge, MIO_ready=0.
REQ-034 Assert reset during BUSY of a write to 0x20 -> outputs go 0 without a clock edge; RAM word 0x20 is unchanged on a later read; WAIT_CYCLES=0 build gives MIO_ready 1 cycle after acceptance.

Source files
------------

// File: rtl/mio_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mio_responder_if
//  Description : CPU-side memory/IO bus of the MIO responder. The master
//                (CPU) drives a level request with write flag, byte address
//                and write data; the slave returns read data, a ready flag
//                and an error flag for the access.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mio_responder_if;
    logic        mem_req;
    logic        mem_w;
    logic [31:0] M_addr;
    logic [31:0] data_out;
    logic [31:0] data2CPU;
    logic        MIO_ready;
    logic        bus_err;

    modport master (
        output mem_req,
        output mem_w,
        output M_addr,
        output data_out,
        input  data2CPU,
        input  MIO_ready,
        input  bus_err
    );

    modport slave (
        input  mem_req,
        input  mem_w,
        input  M_addr,
        input  data_out,
        output data2CPU,
        output MIO_ready,
        output bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mio_responder
//  Description : Memory/IO responder for a simple CPU bus. Serves a
//                2^RAM_AW x 32 internal RAM at address 0, a 16-bit LED
//                register at IO_BASE and the 16 switch inputs at IO_BASE+4.
//                Each access is a four-phase handshake: the request is
//                latched in IDLE, optionally delayed WAIT_CYCLES cycles in
//                BUSY, and answered in DONE until the request is dropped.
//                Misaligned or unmapped accesses raise bus_err and have no
//                side effect.
//  Revision    : 1.0 - initial release
// ============================================================================
module mio_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned RAM_AW      = 10,
    parameter logic [31:0] IO_BASE     = 32'hF000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mio_responder_if.slave   bus,
    input  wire logic [15:0] sw_in,
    output logic      [15:0] led_out
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_BUSY    = 2'd1;
    localparam logic [1:0]  c_DONE    = 2'd2;
    localparam logic [3:0]  c_WAIT    = 4'(WAIT_CYCLES);
    localparam int          c_DEPTH   = 2 ** RAM_AW;
    localparam logic [31:0] c_LED_ADR = IO_BASE;
    localparam logic [31:0] c_SW_ADR  = IO_BASE + 32'd4;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [3:0]  r_cnt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;

    logic [31:0] r_rdata;
    logic        r_err;
    logic [15:0] r_led;
    logic        r_ready;

    logic [31:0] r_mem [0:c_DEPTH-1];

    // ------------------------------------------------------------------
    // Combinational control and decode
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_enter_done;
    logic              w_ready_d;

    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic              w_we;

    logic              w_misal;
    logic              w_ram_hit;
    logic              w_sel_ram;
    logic              w_sel_led;
    logic              w_sel_sw;
    logic              w_err;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [31:0]       w_rd_mux;

    // State register: asynchronous reset drops any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> (BUSY) -> DONE -> IDLE on request drop
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.mem_req) begin
                    w_next = (c_WAIT == 4'd0) ? c_DONE : c_BUSY;
                end
            end
            c_BUSY: begin
                // The last wait cycle is the one where the counter reads 1;
                // a zero count can never stall the machine here.
                if (r_cnt <= 4'd1) begin
                    w_next = c_DONE;
                end
            end
            c_DONE: begin
                if (!bus.mem_req) begin
                    w_next = c_IDLE;
                end
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // Output logic: handshake strobes derived from the current/next state
    always_comb begin
        w_accept     = (r_state == c_IDLE) && bus.mem_req;
        w_enter_done = (r_state != c_DONE) && (w_next == c_DONE);
        // Ready goes high on the first edge spent wholly inside DONE and
        // drops on the same edge that returns the machine to IDLE.
        w_ready_d    = (r_state == c_DONE) && (w_next == c_DONE);
    end

    // Effective access fields: with no wait cycles DONE is entered on the
    // acceptance edge itself, before the latches hold the request.
    always_comb begin
        if (r_state == c_IDLE) begin
            w_addr  = bus.M_addr;
            w_wdata = bus.data_out;
            w_we    = bus.mem_w;
        end else begin
            w_addr  = r_addr;
            w_wdata = r_wdata;
            w_we    = r_we;
        end
    end

    // Address decode: RAM first, then LED and switch registers; any
    // misaligned address is an error whatever region it falls in.
    always_comb begin
        w_misal   = |w_addr[1:0];
        w_ram_hit = (w_addr[31:RAM_AW+2] == '0);
        w_sel_ram = !w_misal && w_ram_hit;
        w_sel_led = !w_misal && !w_ram_hit && (w_addr == c_LED_ADR);
        w_sel_sw  = !w_misal && !w_ram_hit && (w_addr == c_SW_ADR);
        w_err     = !(w_sel_ram || w_sel_led || w_sel_sw);
        w_ram_idx = w_addr[RAM_AW+1:2];
    end

    // Read data mux for the access being completed
    always_comb begin
        w_rd_mux = 32'h0;
        if (w_sel_ram) begin
            w_rd_mux = r_mem[w_ram_idx];
        end else if (w_sel_led) begin
            w_rd_mux = {16'h0, r_led};
        end else if (w_sel_sw) begin
            w_rd_mux = {16'h0, sw_in};
        end
    end

    // Wait counter: reloaded on acceptance, counts down in BUSY, saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_WAIT;
        end else if ((r_state == c_BUSY) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request latch: later bus activity is ignored until the next IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_we    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= bus.M_addr;
            r_wdata <= bus.data_out;
            r_we    <= bus.mem_w;
        end
    end

    // Response registers: loaded only on the DONE-entry edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
            r_led   <= 16'h0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_ready_d;
            if (w_enter_done) begin
                r_err <= w_err;
                if (w_we) begin
                    // Write: read data holds its previous value
                    if (w_sel_led) begin
                        r_led <= w_wdata[15:0];
                    end
                end else begin
                    r_rdata <= w_rd_mux;
                end
            end
        end
    end

    // RAM write port: contents survive reset, and a write whose DONE entry
    // coincides with reset is suppressed.
    always_ff @(posedge clk) begin
        if (w_enter_done && !reset && w_we && w_sel_ram) begin
            r_mem[w_ram_idx] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.data2CPU  = r_rdata;
    assign bus.MIO_ready = r_ready;
    assign bus.bus_err   = r_err;
    assign led_out       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mio_responder
//  Description : Self-checking bench for mio_responder. Two instances share
//                clock and reset: one with two wait cycles, one with none.
//                Directed steps cover the documented scenarios, followed by
//                randomized accesses checked against an address-map model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mio_responder;

    localparam logic [31:0] IO        = 32'hF000_0000;
    localparam int          RAM_BYTES = 4 << 10;

    logic        clk;
    logic        reset;
    logic [15:0] sw0, sw1;
    logic [15:0] led0, led1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = WAIT_CYCLES 2, index 1 = WAIT_CYCLES 0
    logic [31:0] m_ram [2][1024];
    logic [15:0] m_led [2];
    logic [31:0] m_rd  [2];
    logic        m_err [2];

    mio_responder_if bus0();
    mio_responder_if bus1();

    mio_responder #(.WAIT_CYCLES(2), .RAM_AW(10), .IO_BASE(IO)) u_dut_w2 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus0),
        .sw_in   (sw0),
        .led_out (led0)
    );

    mio_responder #(.WAIT_CYCLES(0), .RAM_AW(10), .IO_BASE(IO)) u_dut_w0 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus1),
        .sw_in   (sw1),
        .led_out (led1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rq, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.mem_req = rq; bus0.mem_w = w; bus0.M_addr = a; bus0.data_out = d;
        end else begin
            bus1.mem_req = rq; bus1.mem_w = w; bus1.M_addr = a; bus1.data_out = d;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus0.MIO_ready : bus1.MIO_ready;
    endfunction
    function automatic logic [31:0] get_data(input int sel);
        return (sel == 0) ? bus0.data2CPU : bus1.data2CPU;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus0.bus_err : bus1.bus_err;
    endfunction
    function automatic logic [15:0] get_led(input int sel);
        return (sel == 0) ? led0 : led1;
    endfunction

    // Address map: 0 = RAM, 1 = LED, 2 = switches, 3 = error
    function automatic int region(input logic [31:0] a);
        if (a % 4 != 0)        return 3;
        if (a < RAM_BYTES)     return 0;
        if (a == IO)           return 1;
        if (a == IO + 32'd4)   return 2;
        return 3;
    endfunction

    task automatic model_update(input int sel, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [15:0] sw);
        int r;
        r = region(a);
        m_err[sel] = (r == 3);
        if (w) begin
            if (r == 0) m_ram[sel][int'(a / 4)] = d;
            if (r == 1) m_led[sel] = d[15:0];
        end else begin
            case (r)
                0:       m_rd[sel] = m_ram[sel][int'(a / 4)];
                1:       m_rd[sel] = {16'h0, m_led[sel]};
                2:       m_rd[sel] = {16'h0, sw};
                default: m_rd[sel] = 32'h0;
            endcase
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_led[s] = 16'h0; m_rd[s] = 32'h0; m_err[s] = 1'b0;
        end
    endtask

    task automatic check_outputs(input int sel, input string tag);
        check({tag, "_data"}, get_data(sel), m_rd[sel]);
        check({tag, "_err"},  32'(get_err(sel)), 32'(m_err[sel]));
        check({tag, "_led"},  32'(get_led(sel)), 32'(m_led[sel]));
    endtask

    // One complete four-phase access; bus fields are scrambled once the
    // request has been taken, and 'hold' extra cycles keep mem_req high
    // while presenting a would-be LED write that must not happen.
    task automatic access(input int sel, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int hold, input string tag);
        int   cyc;
        logic rdy;
        logic [15:0] sw;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        sw = (sel == 0) ? sw0 : sw1;
        @(posedge clk);
        model_update(sel, w, a, d, sw);
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 40) begin
            #1 drive(sel, 1'b1, 1'($urandom()), $urandom(), $urandom());
            @(posedge clk);
            cyc++;
            #1 rdy = get_ready(sel);
        end
        check({tag, "_lat"}, 32'(cyc), (sel == 0) ? 32'd3 : 32'd1);
        check_outputs(sel, tag);
        for (int i = 0; i < hold; i++) begin
            drive(sel, 1'b1, 1'b1, IO, $urandom());
            @(posedge clk);
            #1 check({tag, "_hold_rdy"}, 32'(get_ready(sel)), 32'd1);
        end
        if (hold > 0) check_outputs(sel, {tag, "_hold"});
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1 check({tag, "_drop_rdy"}, 32'(get_ready(sel)), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 6))
            0, 1, 2: return 32'($urandom_range(0, 15)) * 32'd4;
            3:       return 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
            4:       return IO;
            5:       return IO + 32'd4;
            default: return ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | ($urandom() & 32'h0FFF_FFFC))
                                                        : 32'h0000_1000;
        endcase
    endfunction

    initial begin
        int sel;
        reset = 1'b1;
        sw0 = 16'h0;
        sw1 = 16'h0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        model_reset();

        // Reset values
        #2;
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", 32'(get_ready(s)), 32'd0);
            check_outputs(s, "rst");
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // RAM write then read-back, WAIT_CYCLES = 2
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, "ram_wr10");
        access(0, 1'b0, 32'h10, 32'h0, 0, "ram_rd10");
        check("ram_rd10_const", get_data(0), 32'hDEADBEEF);

        // LED register and switch inputs
        access(0, 1'b1, IO, 32'h0000A5A5, 0, "led_wr");
        check("led_const", 32'(led0), 32'h0000A5A5);
        access(0, 1'b0, IO, 32'h0, 0, "led_rd");
        check("led_rd_const", get_data(0), 32'h0000A5A5);
        sw0 = 16'h1234;
        access(0, 1'b0, IO + 32'd4, 32'h0, 0, "sw_rd");
        check("sw_rd_const", get_data(0), 32'h00001234);

        // Error accesses
        access(0, 1'b0, 32'h12, 32'h0, 0, "misal_rd");
        check("misal_err_const", 32'(bus0.bus_err), 32'd1);
        access(0, 1'b0, 32'h8000_0000, 32'h0, 0, "unmap_rd");
        check("unmap_data_const", get_data(0), 32'h0);
        access(0, 1'b1, 32'h12, 32'h11111111, 0, "misal_wr");
        access(0, 1'b0, 32'h10, 32'h0, 0, "ram_rd10_after");
        check("misal_wr_noeffect", get_data(0), 32'hDEADBEEF);

        // Request held well past ready
        access(0, 1'b0, 32'h10, 32'h0, 5, "hold");

        // Reset during BUSY of a write to 0x20
        access(0, 1'b1, 32'h20, 32'h20202020, 0, "ram_wr20");
        access(0, 1'b0, 32'h20, 32'h0, 0, "ram_rd20");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'hBAD0BAD0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("abort_ready", 32'(get_ready(0)), 32'd0);
        check_outputs(0, "abort");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk) reset = 1'b0;
        access(0, 1'b0, 32'h20, 32'h0, 0, "ram_rd20_after");
        check("abort_ram_const", get_data(0), 32'h20202020);

        // Zero-wait build
        access(1, 1'b1, 32'h20, 32'hCAFEF00D, 0, "w0_wr20");
        access(1, 1'b0, 32'h20, 32'h0, 0, "w0_rd20");
        check("w0_rd20_const", get_data(1), 32'hCAFEF00D);

        // Fill the first 16 RAM words of both instances
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                access(s, 1'b1, 32'(i) * 32'd4, $urandom(), 0, "fill");
            end
        end

        // Randomized accesses
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 1));
            sw0 = 16'($urandom());
            sw1 = 16'($urandom());
            access(sel, 1'($urandom()), rand_addr(), $urandom(),
                   int'($urandom_range(0, 2)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
